mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester round-robin arbiter for the CPU's single shared memory port. Instruction fetch and data access each request the port. The arbiter picks one requester, holds the grant until the memory signals completion, and drives the select line of the 2:1 mux bank that steers address, write data and write enable onto the port. It sits between the fetch/memory-stage request logic and the memory model.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width
- clk  input  1  rising-edge clock, the only clock
- reset  input  1  synchronous, active-high reset
- req0, req1  input  1  level request from requester 0 (fetch) and requester 1 (data)
- addr0, addr1  input  ADDR_W  request addresses
- wdata0, wdata1  input  DATA_W  write data
- we0, we1  input  1  write enable per requester
- mem_ready  input  1  memory completion, one-cycle pulse
- mem_rdata  input  DATA_W  read data from memory, valid when mem_ready=1
- mem_valid  output  1  access in progress toward memory
- mem_addr  output  ADDR_W  steered address
- mem_wdata  output  DATA_W  steered write data
- mem_we  output  1  steered write enable, gated by mem_valid
- mem_sel  output  1  mux-bank select, 0 = requester 0, 1 = requester 1
- gnt0, gnt1  output  1  one-hot grant
- done0, done1  output  1  completion pulse to the owning requester
- rdata  output  DATA_W  mem_rdata passed through, valid with done0/done1

## Operation
- States: IDLE, BUSY0, BUSY1. The state and a priority bit prio are registered. prio=n means requester n wins a tie.
- IDLE:
  - Only req0 high: next state BUSY0.
  - Only req1 high: next state BUSY1.
  - Both high: next state BUSY{prio}.
  - Neither high: stay in IDLE.
- BUSYn:
  - gnt_n=1, mem_sel=n, mem_valid=1.
  - mem_addr, mem_wdata and mem_we come from requester n through the mux bank.
  - mem_ready=0: stay in BUSYn.
  - mem_ready=1: done_n=1 combinationally in that cycle; next state IDLE; prio takes the value (1-n).
- IDLE outputs: mem_valid=0, mem_we=0, gnt0=gnt1=0, mem_sel=0. mem_addr and mem_wdata show requester 0's values; they are don't-care.
- Requester obligations:
  - Hold req, addr, wdata and we stable from assertion until done.
  - Clear req on the clock edge where done is high.
  - A req still high in the following IDLE cycle counts as a new request.
- mem_ready is ignored in IDLE.
- A deasserted req during BUSY is ignored. The access completes and done still pulses.
- The grant never changes in the middle of an access. There is no preemption and no timeout.
- rdata = mem_rdata at all times.

## Timing
- Reset, the cycle after reset is sampled high:
  - state = IDLE, prio = 0.
  - All outputs 0, except mem_addr, mem_wdata and rdata, which follow their inputs.
- Reset during BUSY aborts the access. mem_valid drops the next cycle and no done is issued.
- Grant latency: req sampled in IDLE at edge t gives gnt and mem_valid during cycle t+1.
- Completion: done_n is high in the same cycle as mem_ready. The arbiter is in IDLE one cycle later.
- Minimum period is 2 cycles per access: one BUSY cycle with immediate mem_ready, plus one IDLE cycle.
- With both requesters continuously requesting, grants strictly alternate.
- gnt0 and gnt1 are never both high. done_n never pulses without gnt_n high in the same cycle.

## Test plan
- **Reset, then req0 only:**
  - Stimulus: reset, then req0=1, addr0=0x100, we0=0; mem_ready pulses in the 3rd BUSY cycle.
  - Required: gnt0=1 and mem_sel=0 for 3 cycles; mem_addr=0x100; done0 in the 3rd cycle; rdata equals mem_rdata (0xDEAD); IDLE afterwards.
- **Tie after reset:**
  - Stimulus: req0=req1=1 in the same cycle; mem_ready=1 immediately.
  - Required: BUSY0 first, prio becomes 1. Requester 0 drops its req and requester 1 holds its req, so BUSY1 follows: gnt1=1, mem_sel=1, mem_addr=addr1.
- **Sustained contention:**
  - Stimulus: both requesters re-request immediately, 8 accesses, mem_ready=1 on the first BUSY cycle.
  - Required: grant order 0,1,0,1,0,1,0,1; one IDLE cycle between accesses.
- **Write steering:**
  - Stimulus: req1=1, we1=1, wdata1=0xA5A5, with req0 also high and we0=0.
  - Required, when granted: mem_we=1, mem_wdata=0xA5A5. mem_we never goes high while requester 0 owns the port or in IDLE.
- **Reset mid-access:**
  - Stimulus: assert reset while in BUSY1, before mem_ready.
  - Required: next cycle state IDLE, gnt1=0, mem_valid=0, no done1, prio=0. A subsequent tie grants requester 0.
- **Stray mem_ready and early req drop:**
  - Stimulus: mem_ready pulses in IDLE; later, req0 drops during BUSY0.
  - Required: no done and no state change for the IDLE pulse. For BUSY0: gnt0 held until mem_ready, then done0 pulses.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request, steering and completion signals of the shared memory port
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              we0;
    logic              we1;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_sel;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata;

    modport slave (
        input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, mem_ready, mem_rdata,
        output mem_valid, mem_addr, mem_wdata, mem_we, mem_sel, gnt0, gnt1, done0, done1, rdata
    );

    modport master (
        output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, mem_ready, mem_rdata,
        input  mem_valid, mem_addr, mem_wdata, mem_we, mem_sel, gnt0, gnt1, done0, done1, rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter for the single shared memory port
module mem_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t r_state;
    logic   r_prio;
    logic   r_gnt0;
    logic   r_gnt1;
    logic   r_valid;
    logic   r_sel;

    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_we;
    logic              w_pick0;

    // Requester 0 wins when alone or when a tie falls to it.
    assign w_pick0 = bus.req0 && (!bus.req1 || !r_prio);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_prio  <= 1'b0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_valid <= 1'b0;
            r_sel   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick0) begin
                        r_state <= BUSY0;
                        r_gnt0  <= 1'b1;
                        r_valid <= 1'b1;
                        r_sel   <= 1'b0;
                    end else if (bus.req1) begin
                        r_state <= BUSY1;
                        r_gnt1  <= 1'b1;
                        r_valid <= 1'b1;
                        r_sel   <= 1'b1;
                    end
                end
                BUSY0: begin
                    if (bus.mem_ready) begin
                        r_state <= IDLE;
                        r_gnt0  <= 1'b0;
                        r_valid <= 1'b0;
                        r_prio  <= 1'b1;
                    end
                end
                BUSY1: begin
                    if (bus.mem_ready) begin
                        r_state <= IDLE;
                        r_gnt1  <= 1'b0;
                        r_valid <= 1'b0;
                        r_sel   <= 1'b0;
                        r_prio  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_valid <= 1'b0;
                    r_sel   <= 1'b0;
                end
            endcase
        end
    end

    // Mux bank: select rests at 0 in IDLE, so requester 0 values show through.
    assign w_addr  = r_sel ? bus.addr1  : bus.addr0;
    assign w_wdata = r_sel ? bus.wdata1 : bus.wdata0;
    assign w_we    = r_sel ? bus.we1    : bus.we0;

    assign bus.mem_valid = r_valid;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_wdata = w_wdata;
    assign bus.mem_we    = r_valid & w_we;
    assign bus.mem_sel   = r_sel;
    assign bus.gnt0      = r_gnt0;
    assign bus.gnt1      = r_gnt1;
    assign bus.done0     = r_gnt0 & bus.mem_ready;
    assign bus.done1     = r_gnt1 & bus.mem_ready;
    assign bus.rdata     = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // {gnt0, gnt1, mem_sel, mem_valid, mem_we, done0, done1}
    logic [6:0] st;
    assign st = {bus.gnt0, bus.gnt1, bus.mem_sel, bus.mem_valid, bus.mem_we, bus.done0, bus.done1};

    localparam logic [6:0] S_IDLE   = 7'b0000000;
    localparam logic [6:0] S_B0     = 7'b1001000;
    localparam logic [6:0] S_B0_RDY = 7'b1001010;
    localparam logic [6:0] S_B1     = 7'b0111000;
    localparam logic [6:0] S_B1_RDY = 7'b0111001;
    localparam logic [6:0] S_B1_W   = 7'b0111100;
    localparam logic [6:0] S_B1_WR  = 7'b0111101;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.addr0 = 64'h55;
        bus.mem_rdata = 64'h1234;
        next_cycle();
        next_cycle();
        @(negedge clk);
        total++;
        if (st !== S_IDLE) begin
            bad++;
            $display("FAIL reset_outputs: got %b want %b", st, S_IDLE);
        end
        total++;
        if (bus.mem_addr !== 64'h55) begin
            bad++;
            $display("FAIL reset_addr: got %h want %h", bus.mem_addr, 64'h55);
        end
        total++;
        if (bus.rdata !== 64'h1234) begin
            bad++;
            $display("FAIL reset_rdata: got %h want %h", bus.rdata, 64'h1234);
        end
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_req0_only();
        bus.req0 = 1'b1;
        bus.addr0 = 64'h100;
        bus.we0 = 1'b0;
        @(negedge clk);
        total++;
        if (st !== S_IDLE) begin
            bad++;
            $display("FAIL r0_idle_before_grant: got %b want %b", st, S_IDLE);
        end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 64'hDEAD;
            end
            @(negedge clk);
            total++;
            if (st !== ((i == 2) ? S_B0_RDY : S_B0)) begin
                bad++;
                $display("FAIL r0_busy_cycle%0d: got %b want %b", i, st, (i == 2) ? S_B0_RDY : S_B0);
            end
            total++;
            if (bus.mem_addr !== 64'h100) begin
                bad++;
                $display("FAIL r0_addr_cycle%0d: got %h want %h", i, bus.mem_addr, 64'h100);
            end
            if (i == 2) begin
                total++;
                if (bus.rdata !== 64'hDEAD) begin
                    bad++;
                    $display("FAIL r0_rdata: got %h want %h", bus.rdata, 64'hDEAD);
                end
            end
            next_cycle();
        end
        bus.req0 = 1'b0;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (st !== S_IDLE) begin
                bad++;
                $display("FAIL r0_idle_after%0d: got %b want %b", i, st, S_IDLE);
            end
            next_cycle();
        end
    endtask

    task automatic test_tie();
        do_reset();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.addr0 = 64'h200;
        bus.addr1 = 64'h300;
        @(negedge clk);
        total++;
        if (st !== S_IDLE) begin
            bad++;
            $display("FAIL tie_idle: got %b want %b", st, S_IDLE);
        end
        next_cycle();
        bus.mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (st !== S_B0_RDY || bus.mem_addr !== 64'h200) begin
            bad++;
            $display("FAIL tie_first_busy0: got %b/%h want %b/%h", st, bus.mem_addr, S_B0_RDY, 64'h200);
        end
        next_cycle();
        bus.req0 = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (st !== S_IDLE) begin
            bad++;
            $display("FAIL tie_gap_idle: got %b want %b", st, S_IDLE);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (st !== S_B1 || bus.mem_addr !== 64'h300) begin
            bad++;
            $display("FAIL tie_then_busy1: got %b/%h want %b/%h", st, bus.mem_addr, S_B1, 64'h300);
        end
        next_cycle();
        bus.mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (st !== S_B1_RDY) begin
            bad++;
            $display("FAIL tie_done1: got %b want %b", st, S_B1_RDY);
        end
        next_cycle();
        bus.req1 = 1'b0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_contention();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.addr0 = 64'h10;
        bus.addr1 = 64'h20;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++;
            if (st !== S_IDLE) begin
                bad++;
                $display("FAIL cont_idle%0d: got %b want %b", k, st, S_IDLE);
            end
            next_cycle();
            bus.mem_ready = 1'b1;
            @(negedge clk);
            total++;
            if (st !== ((k % 2 == 1) ? S_B1_RDY : S_B0_RDY)) begin
                bad++;
                $display("FAIL cont_grant%0d: got %b want %b", k, st, (k % 2 == 1) ? S_B1_RDY : S_B0_RDY);
            end
            next_cycle();
            bus.mem_ready = 1'b0;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        next_cycle();
    endtask

    task automatic test_write();
        bus.req0 = 1'b1;
        bus.we0 = 1'b0;
        bus.addr0 = 64'h40;
        bus.wdata0 = 64'h1111;
        bus.req1 = 1'b1;
        bus.we1 = 1'b1;
        bus.wdata1 = 64'hA5A5;
        @(negedge clk);
        total++;
        if (st !== S_IDLE) begin
            bad++;
            $display("FAIL wr_idle_we: got %b want %b", st, S_IDLE);
        end
        next_cycle();
        bus.mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (st !== S_B0_RDY) begin
            bad++;
            $display("FAIL wr_busy0_no_we: got %b want %b", st, S_B0_RDY);
        end
        next_cycle();
        bus.req0 = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (st !== S_IDLE) begin
            bad++;
            $display("FAIL wr_gap_idle: got %b want %b", st, S_IDLE);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (st !== S_B1_W || bus.mem_wdata !== 64'hA5A5) begin
            bad++;
            $display("FAIL wr_busy1: got %b/%h want %b/%h", st, bus.mem_wdata, S_B1_W, 64'hA5A5);
        end
        next_cycle();
        bus.mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (st !== S_B1_WR || bus.mem_wdata !== 64'hA5A5) begin
            bad++;
            $display("FAIL wr_busy1_done: got %b/%h want %b/%h", st, bus.mem_wdata, S_B1_WR, 64'hA5A5);
        end
        next_cycle();
        bus.req1 = 1'b0;
        bus.we1 = 1'b0;
        bus.mem_ready = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        bus.req0 = 1'b1;
        next_cycle();
        bus.mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (st !== S_B0_RDY) begin
            bad++;
            $display("FAIL rm_setup_busy0: got %b want %b", st, S_B0_RDY);
        end
        next_cycle();
        bus.req0 = 1'b0;
        bus.mem_ready = 1'b0;
        bus.req1 = 1'b1;
        next_cycle();
        @(negedge clk);
        total++;
        if (st !== S_B1) begin
            bad++;
            $display("FAIL rm_busy1: got %b want %b", st, S_B1);
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        bus.req0 = 1'b1;
        @(negedge clk);
        total++;
        if (st !== S_IDLE) begin
            bad++;
            $display("FAIL rm_after_reset: got %b want %b", st, S_IDLE);
        end
        next_cycle();
        bus.mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (st !== S_B0_RDY) begin
            bad++;
            $display("FAIL rm_tie_grants0: got %b want %b", st, S_B0_RDY);
        end
        next_cycle();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.mem_ready = 1'b0;
        next_cycle();
    endtask

    task automatic test_stray();
        bus.mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (st !== S_IDLE) begin
            bad++;
            $display("FAIL stray_ready_idle: got %b want %b", st, S_IDLE);
        end
        next_cycle();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (st !== S_IDLE) begin
            bad++;
            $display("FAIL stray_no_change: got %b want %b", st, S_IDLE);
        end
        bus.req0 = 1'b1;
        next_cycle();
        @(negedge clk);
        total++;
        if (st !== S_B0) begin
            bad++;
            $display("FAIL drop_busy0_c1: got %b want %b", st, S_B0);
        end
        bus.req0 = 1'b0;
        next_cycle();
        @(negedge clk);
        total++;
        if (st !== S_B0) begin
            bad++;
            $display("FAIL drop_busy0_c2: got %b want %b", st, S_B0);
        end
        next_cycle();
        bus.mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (st !== S_B0_RDY) begin
            bad++;
            $display("FAIL drop_done0: got %b want %b", st, S_B0_RDY);
        end
        next_cycle();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (st !== S_IDLE) begin
                bad++;
                $display("FAIL drop_idle%0d: got %b want %b", i, st, S_IDLE);
            end
            next_cycle();
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.addr0 = '0;
        bus.addr1 = '0;
        bus.wdata0 = '0;
        bus.wdata1 = '0;
        bus.we0 = 1'b0;
        bus.we1 = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        test_reset();
        test_req0_only();
        test_tie();
        test_contention();
        test_write();
        test_reset_mid();
        test_stray();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
